mr_wb_arb: RTL and testbench
============================

// Module: mr_wb_arb
// PURPOSE
//  Two-master, one-slave pipelined Wishbone (B4) arbiter. Shares the single memory bus between
//  instruction fetch (m0) and the load/store unit (m1). Holds a grant for a whole bus cycle
//  (cyc) and uses round-robin between the two masters.
//  Includes an ack watchdog: a hung slave produces a bus error instead of a core deadlock.
// PARAMETERS
//  AW           30    word-address width (XLEN-XLEN_GRAN)
//  DW           32    data width; select width is DW/8
//  TIMEOUT      255   cycles without ack/err before watchdog error; 0 disables the watchdog
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  mN_cyc_i     in   1      master N (N=0 fetch, N=1 ldst) bus cycle
//  mN_stb_i     in   1      master N strobe
//  mN_we_i      in   1      master N write enable
//  mN_addr_i    in   AW     master N word address
//  mN_sel_i     in   DW/8   master N byte selects
//  mN_dat_i     in   DW     master N write data
//  mN_ack_o     out  1      ack routed to master N
//  mN_err_o     out  1      error routed to master N (slave err or watchdog)
//  mN_stall_o   out  1      stall routed to master N
//  mN_dat_o     out  DW     read data (s_dat_i fanned out to both masters)
//  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o, s_dat_o   out   slave-side mux of granted master
//  s_ack_i, s_err_i, s_stall_i   in  1    slave responses
//  s_dat_i      in   DW     slave read data
// BEHAVIOUR
//  - FSM states: IDLE, OWN0, OWN1. A registered grant gives 1 cycle of arbitration latency.
//  - IDLE: request = mN_cyc_i & mN_stb_i.
//    - Single requester: go to OWNN.
//    - Both requesting: grant the master that was not granted last; last_gnt resets to 1, so m0 wins first.
//  - OWNN: s_* = mN_* with s_cyc_o = s_stb_o gated by grant.
//    - mN_ack_o = s_ack_i; mN_err_o = s_err_i | wd_err; mN_stall_o = s_stall_i.
//    - The other master sees ack=0, err=0, stall=1.
//  - Release: in OWNN, when mN_cyc_i==0, return to IDLE and set last_gnt=N. s_cyc_o drops combinationally
//    in that same cycle. No back-to-back regrant without IDLE (one dead cycle between owners).
//  - In IDLE, all s_cyc_o/s_stb_o = 0 and every mN_stall_o = 1, so requests are never lost.
//  - Outstanding counter (4 bits): +1 on s_stb_o & !s_stall_i; -1 on s_ack_i. Increment and decrement
//    in the same cycle leave it unchanged.
//  - The counter is cleared on release, on s_err_i and on wd_err. A master dropping cyc with acks
//    pending abandons them.
//  - Acks arriving in IDLE are discarded.
//  - Watchdog: wd_cnt (8 bits min, sized from TIMEOUT) is cleared when any of these holds:
//    - s_ack_i or s_err_i;
//    - outstanding==0 and no stb.
//  - Otherwise wd_cnt increments while owned.
//  - When wd_cnt==TIMEOUT, wd_err is pulsed for 1 cycle to the owner; s_cyc_o is forced to 0 that
//    cycle; the FSM returns to IDLE; the counter is cleared.
//  - Simultaneous s_ack_i and wd_err is impossible by construction: ack clears the counter first.
//  - Reset: state=IDLE, last_gnt=1, counters=0. All outputs are combinational from state, so after
//    reset s_cyc_o=s_stb_o=0, mN_ack_o=mN_err_o=0, mN_stall_o=1.
//  - Reset mid-transaction: the bus is dropped the next cycle with no ack delivered. The slave's
//    in-flight ack is ignored.
// STRUCTURE
//  - Shared package mr_pkg: typedef enum e_arb_state {ARB_IDLE, ARB_OWN0, ARB_OWN1}.
//  - Shared package mr_pkg: a packed struct wb_req_t {cyc, stb, we, addr, sel, dat}, reused by
//    fetch and ldst.
//  - Sub-module mr_wb_watchdog (counter + compare, TIMEOUT param) keeps the arbiter FSM a pure mux/FSM.
//  - Include fwb_slave per master port and fwb_master on the slave port under FORMAL.
// TESTING
//  1. m1 only: m1 stb to addr 0x100, slave acks 2 cycles later.
//     -> s_cyc_o rises 1 cycle after request; m1_ack_o rises with s_ack_i; m0_stall_o=1 throughout.
//  2. Both masters request in the same cycle after reset.
//     -> m0 granted first; m1 granted after m0 drops cyc plus 1 IDLE cycle; a second tie goes to m1.
//  3. Pipelined m0 burst of 4 stbs, slave stalls 2 of them.
//     -> exactly 4 s_stb_o handshakes and 4 m0 acks; outstanding returns to 0.
//  4. Slave never acks, TIMEOUT=8.
//     -> m1_err_o pulses exactly 8 cycles after the last progress; s_cyc_o=0 that cycle; m0 granted next.
//  5. Reset asserted while m1 owns the bus with 1 ack outstanding.
//     -> next cycle s_cyc_o=0, state IDLE; the late s_ack_i produces no mN_ack_o.
//  6. s_err_i during an m0 read.
//     -> m0_err_o=1 same cycle; m1_err_o=0; outstanding cleared.

Source files
------------

// File: rtl/mr_pkg.sv
// Shared memory-bus types: arbiter state encoding, the Wishbone request bundle
// used by fetch and load/store, and watchdog counter sizing.
package mr_pkg;

  localparam int WB_AW = 30;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } e_arb_state;

  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_AW-1:0]     addr;
    logic [WB_DW/8-1:0]   sel;
    logic [WB_DW-1:0]     dat;
  } wb_req_t;

  // Watchdog counter is at least 8 bits, wider only when TIMEOUT needs it.
  function automatic int wd_width(input int timeout);
    return (timeout < 256) ? 8 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mr_wb_watchdog.sv
// Ack watchdog: counts owned cycles without bus progress and pulses wd_err_o
// for one cycle when the count reaches TIMEOUT (TIMEOUT=0 disables it).
module mr_wb_watchdog
  import mr_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic own_i,
  input  logic rsp_i,
  input  logic quiet_i,
  output logic wd_err_o
);

  localparam int CW = wd_width(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit;

  // A response in the same cycle always wins over the timeout.
  assign hit      = (TIMEOUT != 0) && own_i && !rsp_i && (cnt_q == CW'(TIMEOUT));
  assign wd_err_o = hit;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!own_i || rsp_i || quiet_i || hit) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mr_wb_arb.sv
// Two-master pipelined Wishbone B4 arbiter (m0 = fetch, m1 = load/store) with
// round-robin tie-break, whole-cycle grant hold and an ack watchdog.
module mr_wb_arb
  import mr_pkg::*;
#(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_stall_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_stall_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_stall_i,
  input  logic [DW-1:0]   s_dat_i
);

  e_arb_state state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [3:0] outst_q, outst_d;
  logic       req0, req1, own, own0, own1, wd_err, accept, release_c;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign own0 = (state_q == ARB_OWN0);
  assign own1 = (state_q == ARB_OWN1);
  assign own  = own0 | own1;

  // Slave side follows the owner; a watchdog hit forces the bus off this cycle.
  assign s_cyc_o  = own & !wd_err & (own1 ? m1_cyc_i : m0_cyc_i);
  assign s_stb_o  = own & !wd_err & (own1 ? m1_stb_i : m0_stb_i);
  assign s_we_o   = own1 ? m1_we_i   : m0_we_i;
  assign s_addr_o = own1 ? m1_addr_i : m0_addr_i;
  assign s_sel_o  = own1 ? m1_sel_i  : m0_sel_i;
  assign s_dat_o  = own1 ? m1_dat_i  : m0_dat_i;

  assign m0_ack_o   = own0 & s_ack_i;
  assign m0_err_o   = own0 & (s_err_i | wd_err);
  assign m0_stall_o = !own0 | s_stall_i | wd_err;
  assign m0_dat_o   = s_dat_i;
  assign m1_ack_o   = own1 & s_ack_i;
  assign m1_err_o   = own1 & (s_err_i | wd_err);
  assign m1_stall_o = !own1 | s_stall_i | wd_err;
  assign m1_dat_o   = s_dat_i;

  assign accept    = s_stb_o & !s_stall_i;
  assign release_c = own & (wd_err | !(own1 ? m1_cyc_i : m0_cyc_i));

  mr_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .reset    (reset),
    .own_i    (own),
    .rsp_i    (s_ack_i | s_err_i),
    .quiet_i  ((outst_q == 4'd0) && !s_stb_o),
    .wd_err_o (wd_err)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    outst_d    = outst_q;
    unique case (state_q)
      ARB_IDLE: begin
        outst_d = '0;
        if (req0 && req1) state_d = last_gnt_q ? ARB_OWN0 : ARB_OWN1;
        else if (req0)    state_d = ARB_OWN0;
        else if (req1)    state_d = ARB_OWN1;
      end
      ARB_OWN0, ARB_OWN1: begin
        outst_d = outst_q + {3'b000, accept} - {3'b000, s_ack_i};
        // Dropping cyc abandons any acks still in flight.
        if (release_c || s_err_i) outst_d = '0;
        if (release_c) begin
          state_d    = ARB_IDLE;
          last_gnt_d = own1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= 1'b1;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      outst_q    <= outst_d;
    end
  end

`ifdef FORMAL
  logic [3:0] f0_nreqs, f0_nacks, f0_outst, f1_nreqs, f1_nacks, f1_outst;
  logic [3:0] fs_nreqs, fs_nacks, fs_outst;

  fwb_slave #(.AW(AW), .DW(DW), .F_LGDEPTH(4)) f_m0 (
    .i_clk(clk), .i_reset(reset), .i_wb_cyc(m0_cyc_i), .i_wb_stb(m0_stb_i),
    .i_wb_we(m0_we_i), .i_wb_addr(m0_addr_i), .i_wb_data(m0_dat_i), .i_wb_sel(m0_sel_i),
    .i_wb_ack(m0_ack_o), .i_wb_stall(m0_stall_o), .i_wb_idata(m0_dat_o), .i_wb_err(m0_err_o),
    .f_nreqs(f0_nreqs), .f_nacks(f0_nacks), .f_outstanding(f0_outst));

  fwb_slave #(.AW(AW), .DW(DW), .F_LGDEPTH(4)) f_m1 (
    .i_clk(clk), .i_reset(reset), .i_wb_cyc(m1_cyc_i), .i_wb_stb(m1_stb_i),
    .i_wb_we(m1_we_i), .i_wb_addr(m1_addr_i), .i_wb_data(m1_dat_i), .i_wb_sel(m1_sel_i),
    .i_wb_ack(m1_ack_o), .i_wb_stall(m1_stall_o), .i_wb_idata(m1_dat_o), .i_wb_err(m1_err_o),
    .f_nreqs(f1_nreqs), .f_nacks(f1_nacks), .f_outstanding(f1_outst));

  fwb_master #(.AW(AW), .DW(DW), .F_LGDEPTH(4)) f_s (
    .i_clk(clk), .i_reset(reset), .i_wb_cyc(s_cyc_o), .i_wb_stb(s_stb_o),
    .i_wb_we(s_we_o), .i_wb_addr(s_addr_o), .i_wb_data(s_dat_o), .i_wb_sel(s_sel_o),
    .i_wb_ack(s_ack_i), .i_wb_stall(s_stall_i), .i_wb_idata(s_dat_i), .i_wb_err(s_err_i),
    .f_nreqs(fs_nreqs), .f_nacks(fs_nacks), .f_outstanding(fs_outst));
`endif

endmodule

// File: tb/tb_mr_wb_arb.sv
// Bench for mr_wb_arb: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_mr_wb_arb;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic [DW-1:0] m0_dat, m1_dat, s_dat, m0_rdat, m1_rdat, s_rdat;
  logic          m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic          s_cyc, s_stb, s_we, s_ack, s_err, s_stall;

  int tests = 0, fails = 0;
  int own = -1, last = 1, outst = 0, age = 0;
  int hs = 0, a0 = 0, e0 = 0, k_hit = 0, ackp = 1;

  always #5 clk = ~clk;

  mr_wb_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_stall_o(m0_stall), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_stall_o(m1_stall), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr),
    .s_sel_o(s_sel), .s_dat_o(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .s_stall_i(s_stall), .s_dat_i(s_rdat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_sel = '0; m0_dat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_sel = '0; m1_dat = '0;
    s_ack = 0; s_err = 0; s_stall = 0; s_rdat = '0;
  endtask

  // One bus cycle: check outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    logic hit, ecyc, estb, acc, rel;
    int o;
    @(negedge clk);
    o    = own;
    hit  = (o >= 0) && (age == TO) && !s_ack && !s_err;
    ecyc = 1'b0;
    estb = 1'b0;
    if (o == 0) begin ecyc = m0_cyc & !hit; estb = m0_stb & !hit; end
    if (o == 1) begin ecyc = m1_cyc & !hit; estb = m1_stb & !hit; end
    chk("s_cyc", s_cyc, ecyc);
    chk("s_stb", s_stb, estb);
    chk("m0_ack", m0_ack, (o == 0) & s_ack);
    chk("m0_err", m0_err, (o == 0) & (s_err | hit));
    chk("m0_stall", m0_stall, (o != 0) | s_stall | hit);
    chk("m1_ack", m1_ack, (o == 1) & s_ack);
    chk("m1_err", m1_err, (o == 1) & (s_err | hit));
    chk("m1_stall", m1_stall, (o != 1) | s_stall | hit);
    chk("m0_rdat", m0_rdat, s_rdat);
    chk("m1_rdat", m1_rdat, s_rdat);
    if (o == 0) begin
      chk("s_we0", s_we, m0_we); chk("s_addr0", s_addr, m0_addr);
      chk("s_sel0", s_sel, m0_sel); chk("s_dat0", s_dat, m0_dat);
    end
    if (o == 1) begin
      chk("s_we1", s_we, m1_we); chk("s_addr1", s_addr, m1_addr);
      chk("s_sel1", s_sel, m1_sel); chk("s_dat1", s_dat, m1_dat);
    end
    acc = estb & !s_stall;
    if (s_stb && !s_stall) hs++;
    if (m0_ack) a0++;
    if (m0_err) e0++;
    @(posedge clk);
    if (reset) begin
      own = -1; last = 1; outst = 0; age = 0;
    end else if (o < 0) begin
      if (m0_cyc && m0_stb && m1_cyc && m1_stb) own = (last == 1) ? 0 : 1;
      else if (m0_cyc && m0_stb) own = 0;
      else if (m1_cyc && m1_stb) own = 1;
      outst = 0; age = 0;
    end else begin
      rel = hit || ((o == 0) ? !m0_cyc : !m1_cyc);
      if (s_ack || s_err || hit || (outst == 0 && !estb)) age = 0;
      else age = age + 1;
      if (rel || s_err) outst = 0;
      else outst = (outst + int'(acc) - int'(s_ack)) & 15;
      if (rel) begin last = o; own = -1; end
    end
    #1;
  endtask

  initial begin
    reset = 1; quiet();
    @(posedge clk); #1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_stall", {m0_stall, m1_stall}, 2'b11);
    chk("rst_ackerr", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    tick();

    // m1 alone, ack two cycles after the strobe is taken
    m1_cyc = 1; m1_stb = 1; m1_addr = 30'h100; m1_sel = 4'hf; s_rdat = 32'hdead_beef;
    tick();
    chk("t1_s_cyc", s_cyc, 1); chk("t1_addr", s_addr, 30'h100); chk("t1_m0_stall", m0_stall, 1);
    tick();
    m1_stb = 0; tick();
    s_ack = 1; #1;
    chk("t1_ack", m1_ack, 1); chk("t1_m0_ack", m0_ack, 0); chk("t1_m0_stall_b", m0_stall, 1);
    tick();
    s_ack = 0; m1_cyc = 0; tick();
    tick();

    // simultaneous requests after reset, then a second tie
    reset = 1; tick(); reset = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 30'h10; m1_cyc = 1; m1_stb = 1; m1_addr = 30'h20;
    tick();
    chk("t2_first", s_addr, 30'h10); chk("t2_cyc", s_cyc, 1); chk("t2_m1_stall", m1_stall, 1);
    tick();
    m0_stb = 0; s_ack = 1; tick();
    s_ack = 0; m0_cyc = 0; tick();
    chk("t2_dead", s_cyc, 0);
    m0_cyc = 1; m0_stb = 1; m0_addr = 30'h11;
    tick();
    chk("t2_tie2", s_addr, 30'h20); chk("t2_cyc2", s_cyc, 1);
    tick();
    m1_stb = 0; s_ack = 1; tick();
    s_ack = 0; m1_cyc = 0; tick();
    tick();
    chk("t2_m0_again", s_addr, 30'h11);
    tick();
    m0_stb = 0; s_ack = 1; tick();
    s_ack = 0; m0_cyc = 0; tick(); tick();

    // pipelined m0 burst of four with two stalls
    hs = 0; a0 = 0; e0 = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 30'h200; tick();
    s_stall = 1; tick();
    s_stall = 0; tick();
    m0_addr = 30'h201; s_stall = 1; tick();
    s_stall = 0; tick();
    m0_addr = 30'h202; tick();
    m0_addr = 30'h203; s_ack = 1; tick();
    m0_stb = 0; tick(); tick(); tick();
    s_ack = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("t3_handshakes", hs, 4); chk("t3_acks", a0, 4); chk("t3_no_wd", e0, 0);
    m0_cyc = 0; tick(); tick();

    // slave never acks m1: watchdog fires TO cycles after the strobe
    m0_cyc = 1; m0_stb = 1; m0_addr = 30'h40; m1_cyc = 1; m1_stb = 1; m1_addr = 30'h80;
    tick();
    chk("t4_gnt_m1", s_addr, 30'h80);
    tick();
    m1_stb = 0; k_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (m1_err) begin
        k_hit = k;
        chk("t4_cyc_drop", s_cyc, 0); chk("t4_m0_err", m0_err, 0);
        break;
      end
      tick();
    end
    chk("t4_latency", k_hit, TO);
    tick();
    m1_cyc = 0; tick();
    chk("t4_m0_next", s_addr, 30'h40); chk("t4_m0_cyc", s_cyc, 1);
    tick();
    m0_stb = 0; s_ack = 1; tick();
    s_ack = 0; m0_cyc = 0; tick(); tick();

    // reset while m1 has one ack outstanding
    m1_cyc = 1; m1_stb = 1; m1_addr = 30'h300; tick();
    tick();
    m1_stb = 0; reset = 1; tick();
    reset = 0; s_ack = 1; #1;
    chk("t5_cyc", s_cyc, 0); chk("t5_ack1", m1_ack, 0); chk("t5_ack0", m0_ack, 0);
    tick();
    s_ack = 0; m1_cyc = 0; tick();

    // slave error during an m0 read
    m0_cyc = 1; m0_stb = 1; m0_addr = 30'h400; tick(); tick();
    m0_stb = 0; s_err = 1; #1;
    chk("t6_err0", m0_err, 1); chk("t6_err1", m1_err, 0);
    tick();
    s_err = 0; e0 = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_cleared", e0, 0);
    m0_cyc = 0; tick(); tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) ackp = ((n / 500) % 3 == 0) ? 1 : (((n / 500) % 3 == 1) ? 4 : 12);
      reset = ($urandom_range(0, 199) == 0);
      if (m0_cyc) begin if ($urandom_range(0, 7) == 0) m0_cyc = 0; end
      else m0_cyc = ($urandom_range(0, 3) == 0);
      if (m1_cyc) begin if ($urandom_range(0, 7) == 0) m1_cyc = 0; end
      else m1_cyc = ($urandom_range(0, 3) == 0);
      m0_stb  = m0_cyc && ($urandom_range(0, 1) == 1);
      m1_stb  = m1_cyc && ($urandom_range(0, 1) == 1);
      m0_we   = ($urandom_range(0, 1) == 1);  m1_we   = ($urandom_range(0, 1) == 1);
      m0_addr = AW'($urandom);                 m1_addr = AW'($urandom);
      m0_sel  = SW'($urandom);                 m1_sel  = SW'($urandom);
      m0_dat  = $urandom;                      m1_dat  = $urandom;
      s_stall = ($urandom_range(0, 2) == 0);
      s_ack   = ($urandom_range(0, ackp) == 0);
      s_err   = ($urandom_range(0, 63) == 0);
      s_rdat  = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
